// File: rtl/alu_mult_sequencer.sv
// Multi-cycle shift-add multiplier sequencer for the ALU MULT operation.
// Optional macro MULT_EARLY_TERM_EN: leave RUN once the remaining multiplier bits are zero.
module alu_mult_sequencer #(
    parameter int         NBITS   = 32,
    parameter logic [3:0] MULT_OP = 4'b0101
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [3:0]       ALUOperation,
    input  logic             Flush,
    input  logic [NBITS-1:0] ReadData1,
    input  logic [NBITS-1:0] ReadData2,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [NBITS-1:0] ProductHi,
    output logic [NBITS-1:0] ProductLo,
    output logic [1:0]       state_dbg
);

    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2*NBITS-1:0]   mcand;
    logic [NBITS-1:0]     mplr;
    logic [2*NBITS-1:0]   acc;
    logic [2*NBITS-1:0]   acc_next;
    logic [2*NBITS-1:0]   product;
    logic [CW-1:0]        count;
    logic                 accept;
    logic                 run_last;

    assign accept   = (state == IDLE) && Start && (ALUOperation == MULT_OP) && !Flush;
    assign acc_next = mplr[0] ? (acc + mcand) : acc;

`ifdef MULT_EARLY_TERM_EN
    assign run_last = (count == LAST) || ((mplr >> 1) == '0);
`else
    assign run_last = (count == LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush in RUN takes priority over completion so an aborted multiply never pulses Done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN: begin
                if (Flush)         state_next = IDLE;
                else if (run_last) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy  = (state != IDLE);
        Stall = accept || (state == RUN);
        Done  = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            count   <= '0;
            product <= '0;
        end else if (accept) begin
            mcand <= {{NBITS{1'b0}}, ReadData1};
            mplr  <= ReadData2;
            acc   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            count <= count + 1'b1;
            // The product register takes the sum including this cycle's final addition.
            if (state_next == DONE) begin
                product <= acc_next;
            end
        end
    end

    assign ProductHi = product[2*NBITS-1:NBITS];
    assign ProductLo = product[NBITS-1:0];
    assign state_dbg = state;

endmodule
